// File: rtl/link_timer.sv
// link_timer: one-shot delay timer for the link controller.
// IDLE -> COUNT -> DONE Moore FSM with one-hot state and a sticky ERR flag
// for START requests that arrive while a delay is already in flight.
// Optional feature: define LINK_TIMER_RETRIGGER_EN to let a START in COUNT
// or DONE reload the delay instead of flagging ERR.
module link_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             N_RESET,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] DELAY,
  output logic             READY,
  output logic             BUSY,
  output logic [WIDTH-1:0] COUNT,
  output logic             ERR
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b001,
    S_COUNT = 3'b010,
    S_DONE  = 3'b100
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             err_q,   err_d;

  // State, count and error registers; N_RESET clears everything at once.
  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      state_q <= S_IDLE;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Next-state, count and error logic; RESET overrides every other input.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    err_d   = err_q;
    if (RESET) begin
      state_d = S_IDLE;
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (START) begin
            if (DELAY == '0) begin
              state_d = S_DONE;
              count_d = '0;
            end else begin
              state_d = S_COUNT;
              count_d = DELAY;
            end
          end
        end
        S_COUNT: begin
`ifdef LINK_TIMER_RETRIGGER_EN
          if (START) begin
            if (DELAY == '0) begin
              state_d = S_DONE;
              count_d = '0;
            end else begin
              state_d = S_COUNT;
              count_d = DELAY;
            end
          end else if (count_q <= WIDTH'(1)) begin
            state_d = S_DONE;
            count_d = '0;
          end else begin
            count_d = count_q - WIDTH'(1);
          end
`else
          if (START) begin
            err_d = 1'b1;
          end
          // Guard with <= so a corrupted zero count can never wrap.
          if (count_q <= WIDTH'(1)) begin
            state_d = S_DONE;
            count_d = '0;
          end else begin
            count_d = count_q - WIDTH'(1);
          end
`endif
        end
        S_DONE: begin
`ifdef LINK_TIMER_RETRIGGER_EN
          if (START) begin
            if (DELAY == '0) begin
              state_d = S_DONE;
              count_d = '0;
            end else begin
              state_d = S_COUNT;
              count_d = DELAY;
            end
          end
`else
          if (START) begin
            err_d = 1'b1;
          end
`endif
        end
        default: begin
          state_d = S_IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  // Outputs are pure decodes of registered state; illegal codes read as idle.
  assign READY = (state_q == S_DONE);
  assign BUSY  = (state_q == S_COUNT);
  assign COUNT = count_q;
  assign ERR   = err_q;

endmodule
